// File: rtl/seg7_pkg.sv
// Shared types and constants for the BCD counter / seven-segment display path.
//   bcd_t     : one BCD digit (0..9 when valid)
//   BCD_MAX   : largest legal BCD digit value
//   BCD_ZERO  : digit value zero
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = '0;

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the up/down counter, purely combinational.
// Ports:
//   d       : current digit value
//   dig_max : largest value this digit may hold (9, or the MSD limit)
//   up      : 1 = increment, 0 = decrement
//   cin     : step request from the lower digit (carry or borrow)
//   q       : next digit value
//   cout    : step request passed on to the higher digit (carry or borrow)
module bcd_digit_step
    import seg7_pkg::*;
(
    input  bcd_t d,
    input  bcd_t dig_max,
    input  logic up,
    input  logic cin,
    output bcd_t q,
    output logic cout
);

    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                // >= so an out-of-range digit still rolls over cleanly
                if (d >= dig_max) begin
                    q    = BCD_ZERO;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == BCD_ZERO) begin
                    q    = dig_max;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cntupdn_seg7_bcd.sv
// N-digit BCD up/down counter feeding the seven-segment display path.
// Steps once per tick; sync clear and parallel load; wraps or saturates at the
// limits; the most-significant digit may have a reduced maximum (e.g. 0..59).
// Ports:
//   clk         : system clock, rising edge
//   n_rst       : asynchronous active-low reset
//   tick        : count enable, one-cycle pulse
//   up_dn       : 1 = count up, 0 = count down
//   clear       : synchronous clear (highest priority)
//   load        : synchronous parallel load (beats tick)
//   load_val    : BCD value to load, digit 0 in the low nibble
//   seg7val_out : registered BCD digits
//   carry_out   : one-cycle pulse on wrap (up: MAX->0, down: 0->MAX)
//   limit_hit   : one-cycle pulse when a step is refused in saturate mode
//   at_max      : count equals MAX
//   at_zero     : count equals zero
module cntupdn_seg7_bcd
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MSD_MAX    = 9,
    parameter bit          WRAP_EN    = 1'b1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    tick,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] seg7val_out,
    output logic                    carry_out,
    output logic                    limit_hit,
    output logic                    at_max,
    output logic                    at_zero
);

    localparam bcd_t MSD_LIM = bcd_t'(MSD_MAX);

    bcd_t [NUM_DIGITS-1:0] cnt_q, cnt_d;
    bcd_t [NUM_DIGITS-1:0] stepped;
    bcd_t [NUM_DIGITS-1:0] load_clamped;
    bcd_t [NUM_DIGITS-1:0] max_val;
    logic [NUM_DIGITS:0]   chain;
    logic                  carry_q, carry_d;
    logic                  limit_q, limit_d;

    // The chain is always primed; the top gates the result with tick, so the
    // final cout simply means "a step now would cross a limit".
    assign chain[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        localparam bcd_t DigMax = (g == NUM_DIGITS - 1) ? MSD_LIM : BCD_MAX;

        assign max_val[g] = DigMax;
        // Clamping to the digit's own max covers both non-BCD nibbles and an
        // oversized MSD.
        assign load_clamped[g] = (load_val[4*g +: 4] > DigMax) ? DigMax : load_val[4*g +: 4];

        bcd_digit_step u_step (
            .d       (cnt_q[g]),
            .dig_max (DigMax),
            .up      (up_dn),
            .cin     (chain[g]),
            .q       (stepped[g]),
            .cout    (chain[g+1])
        );
    end

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = 1'b0;
        limit_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_clamped;
        end else if (tick) begin
            if (chain[NUM_DIGITS] && !WRAP_EN) begin
                limit_d = 1'b1;
            end else begin
                cnt_d   = stepped;
                carry_d = chain[NUM_DIGITS];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            limit_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            limit_q <= limit_d;
        end
    end

    assign seg7val_out = cnt_q;
    assign carry_out   = carry_q;
    assign limit_hit   = limit_q;
    assign at_max      = (cnt_q == max_val);
    assign at_zero     = (cnt_q == '0);

endmodule

// File: tb/tb_cntupdn_seg7_bcd.sv
// Bench for cntupdn_seg7_bcd: four configurations share one stimulus stream.
// The reference keeps each count as a plain integer in 0..MAX and converts to
// BCD only for comparison.
module tb_cntupdn_seg7_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst, tick, up_dn, clear, load;
    logic [15:0] load_val;
    logic [7:0]  seg_a, seg_b;
    logic [15:0] seg_c;
    logic [3:0]  seg_d;
    logic [3:0]  carry_v, limit_v, amax_v, azero_v;

    // configs: a=2 dig/9/wrap, b=2 dig/5/wrap, c=4 dig/9/sat, d=1 dig/5/sat
    localparam int ND   [4] = '{2, 2, 4, 1};
    localparam int MSDM [4] = '{9, 5, 9, 5};
    localparam int WRP  [4] = '{1, 1, 0, 0};

    cntupdn_seg7_bcd #(.NUM_DIGITS(2), .MSD_MAX(9), .WRAP_EN(1'b1)) u_a (
        .clk(clk), .n_rst(n_rst), .tick(tick), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val[7:0]), .seg7val_out(seg_a), .carry_out(carry_v[0]),
        .limit_hit(limit_v[0]), .at_max(amax_v[0]), .at_zero(azero_v[0])
    );
    cntupdn_seg7_bcd #(.NUM_DIGITS(2), .MSD_MAX(5), .WRAP_EN(1'b1)) u_b (
        .clk(clk), .n_rst(n_rst), .tick(tick), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val[7:0]), .seg7val_out(seg_b), .carry_out(carry_v[1]),
        .limit_hit(limit_v[1]), .at_max(amax_v[1]), .at_zero(azero_v[1])
    );
    cntupdn_seg7_bcd #(.NUM_DIGITS(4), .MSD_MAX(9), .WRAP_EN(1'b0)) u_c (
        .clk(clk), .n_rst(n_rst), .tick(tick), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .seg7val_out(seg_c), .carry_out(carry_v[2]),
        .limit_hit(limit_v[2]), .at_max(amax_v[2]), .at_zero(azero_v[2])
    );
    cntupdn_seg7_bcd #(.NUM_DIGITS(1), .MSD_MAX(5), .WRAP_EN(1'b0)) u_d (
        .clk(clk), .n_rst(n_rst), .tick(tick), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .seg7val_out(seg_d), .carry_out(carry_v[3]),
        .limit_hit(limit_v[3]), .at_max(amax_v[3]), .at_zero(azero_v[3])
    );

    logic [15:0] seg [4];
    assign seg[0] = {8'h00, seg_a};
    assign seg[1] = {8'h00, seg_b};
    assign seg[2] = seg_c;
    assign seg[3] = {12'h000, seg_d};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic int max_of(input int k);
        return MSDM[k] * pow10(ND[k] - 1) + pow10(ND[k] - 1) - 1;
    endfunction

    function automatic int to_int(input logic [15:0] lv, input int k);
        int v = 0;
        for (int i = 0; i < ND[k]; i++) begin
            int d   = int'(lv[4*i +: 4]);
            int lim = (i == ND[k] - 1) ? MSDM[k] : 9;
            if (d > lim) d = lim;
            v += d * pow10(i);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = '0;
        int m = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Reference model
    int   cnt   [4];
    logic exp_c [4];
    logic exp_l [4];

    always @(posedge clk or negedge n_rst) begin
        for (int k = 0; k < 4; k++) begin
            if (!n_rst) begin
                cnt[k]   <= 0;
                exp_c[k] <= 1'b0;
                exp_l[k] <= 1'b0;
            end else begin
                exp_c[k] <= 1'b0;
                exp_l[k] <= 1'b0;
                if (clear) cnt[k] <= 0;
                else if (load) cnt[k] <= to_int(load_val, k);
                else if (tick) begin
                    if (up_dn) begin
                        if (cnt[k] == max_of(k)) begin
                            if (WRP[k] != 0) begin
                                cnt[k]   <= 0;
                                exp_c[k] <= 1'b1;
                            end else exp_l[k] <= 1'b1;
                        end else cnt[k] <= cnt[k] + 1;
                    end else begin
                        if (cnt[k] == 0) begin
                            if (WRP[k] != 0) begin
                                cnt[k]   <= max_of(k);
                                exp_c[k] <= 1'b1;
                            end else exp_l[k] <= 1'b1;
                        end else cnt[k] <= cnt[k] - 1;
                    end
                end
            end
        end
    end

    // Compare every configuration against the model away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cmp%0d seg", k), seg[k], to_bcd(cnt[k]));
            chk($sformatf("cmp%0d carry", k), 16'(carry_v[k]), 16'(exp_c[k]));
            chk($sformatf("cmp%0d limit", k), 16'(limit_v[k]), 16'(exp_l[k]));
            chk($sformatf("cmp%0d at_max", k), 16'(amax_v[k]), 16'(cnt[k] == max_of(k)));
            chk($sformatf("cmp%0d at_zero", k), 16'(azero_v[k]), 16'(cnt[k] == 0));
        end
    end

    task automatic cyc(input logic t, input logic u, input logic c, input logic l,
                       input logic [15:0] lv);
        tick = t; up_dn = u; clear = c; load = l; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b0; tick = 1'b0; up_dn = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        #12;
        chk("reset seg_c", seg_c, 16'h0000);
        chk("reset at_zero", 16'(azero_v), 16'hF);
        chk("reset at_max", 16'(amax_v), 16'h0);
        chk("reset pulses", 16'({carry_v, limit_v}), 16'h00);
        n_rst = 1'b1;

        // 100 up ticks
        repeat (99) cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t1 a=99", 16'(seg_a), 16'h0099);
        chk("t1 b=39", 16'(seg_b), 16'h0039);
        chk("t1 c=0099", seg_c, 16'h0099);
        chk("t1 d sat 5", 16'(seg_d), 16'h0005);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t1 a wrap", 16'(seg_a), 16'h0000);
        chk("t1 a carry", 16'(carry_v[0]), 16'h1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t1 a carry drop", 16'(carry_v[0]), 16'h0);

        // Limited MSD
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0059);
        chk("t2 b=59", 16'(seg_b), 16'h0059);
        chk("t2 b at_max", 16'(amax_v[1]), 16'h1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t2 b up wrap", 16'(seg_b), 16'h0000);
        chk("t2 b carry up", 16'(carry_v[1]), 16'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t2 b down wrap", 16'(seg_b), 16'h0059);
        chk("t2 b carry dn", 16'(carry_v[1]), 16'h1);

        // Saturation
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999);
        chk("t3 b clamp", 16'(seg_b), 16'h0059);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t3 c hold", seg_c, 16'h9999);
        chk("t3 c limit", 16'(limit_v[2]), 16'h1);
        chk("t3 c no carry", 16'(carry_v[2]), 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t3 c hold 0", seg_c, 16'h0000);
        chk("t3 c limit 0", 16'(limit_v[2]), 16'h1);

        // Load clamp and priority
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h00A7);
        chk("t4 a clamp 97", 16'(seg_a), 16'h0097);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0055);
        chk("t4 clear wins", 16'(seg_a), 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0042);
        chk("t4 load beats tick", 16'(seg_a), 16'h0042);
        chk("t4 no pulse", 16'({carry_v, limit_v}), 16'h00);

        // Ripple borrow and carry
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h1000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t5 borrow", seg_c, 16'h0999);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0999);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t5 carry ripple", seg_c, 16'h1000);
        chk("t5 no pulse", 16'({carry_v[2], limit_v[2]}), 16'h0);

        // Back-to-back ticks, then async reset mid-sequence
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0008);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t6 09", 16'(seg_a), 16'h0009);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t6 10", 16'(seg_a), 16'h0010);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t6 11", 16'(seg_a), 16'h0011);
        #3 n_rst = 1'b0;
        #1;
        chk("t6 async a", 16'(seg_a), 16'h0000);
        chk("t6 async c", seg_c, 16'h0000);
        chk("t6 async zero", 16'(azero_v), 16'hF);
        chk("t6 async pulses", 16'({carry_v, limit_v}), 16'h00);
        #2 n_rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("t6 step from 0", 16'(seg_a), 16'h0001);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, r < 3,
                (r >= 3) && (r < 9), 16'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                #2 n_rst = 1'b0;
                #2 n_rst = 1'b1;
            end
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
